// File: rtl/rgb_to_ycbcr_planar.sv
// RGB -> planar YCbCr front end: streams Y per pixel, buffers Cb/Cr and drains them after the luma plane.
// Optional tlast framing check enabled by defining CSC_TLAST_CHECK_EN.
module rgb_to_ycbcr_planar #(
  parameter int PIXELS = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        frame_err
);

  localparam int AW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(PIXELS - 1);

  typedef enum logic [1:0] {LUMA, CB, CR} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pix_cnt, rd_cnt;
  logic [7:0]    cb_buf [PIXELS];
  logic [7:0]    cr_buf [PIXELS];
  logic          load, accept;

  logic signed [17:0] r_s, g_s, b_s;
  logic signed [17:0] y_sum, cb_sum, cr_sum;
  logic [7:0]         y_val, cb_val, cr_val;

  function automatic logic [7:0] clamp8(input logic signed [17:0] v);
    if (v < 18'sd0)
      clamp8 = 8'd0;
    else if (v > 18'sd255)
      clamp8 = 8'd255;
    else
      clamp8 = v[7:0];
  endfunction

  assign r_s = $signed({10'd0, s_axis_tdata[23:16]});
  assign g_s = $signed({10'd0, s_axis_tdata[15:8]});
  assign b_s = $signed({10'd0, s_axis_tdata[7:0]});

  assign y_sum  = (18'sd77 * r_s + 18'sd150 * g_s + 18'sd29 * b_s + 18'sd128) >>> 8;
  assign cb_sum = ((-18'sd43 * r_s - 18'sd85 * g_s + 18'sd128 * b_s + 18'sd128) >>> 8) + 18'sd128;
  assign cr_sum = ((18'sd128 * r_s - 18'sd107 * g_s - 18'sd21 * b_s + 18'sd128) >>> 8) + 18'sd128;

  assign y_val  = clamp8(y_sum);
  assign cb_val = clamp8(cb_sum);
  assign cr_val = clamp8(cr_sum);

  always_ff @(posedge aclk) begin
    if (!aresetn)
      state <= LUMA;
    else
      state <= state_nxt;
  end

  // Input is only taken while the output register can accept the matching Y byte.
  always_comb begin
    state_nxt     = state;
    load          = !m_axis_tvalid || m_axis_tready;
    s_axis_tready = 1'b0;
    accept        = 1'b0;
    case (state)
      LUMA: begin
        s_axis_tready = load && aresetn;
        accept        = s_axis_tvalid && load && aresetn;
        if (accept && pix_cnt == LAST_IDX)
          state_nxt = CB;
      end
      CB: begin
        if (load && rd_cnt == LAST_IDX)
          state_nxt = CR;
      end
      CR: begin
        if (load && rd_cnt == LAST_IDX)
          state_nxt = LUMA;
      end
      default: state_nxt = LUMA;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'd0;
      m_axis_tlast  <= 1'b0;
      pix_cnt       <= '0;
      rd_cnt        <= '0;
    end else begin
      case (state)
        LUMA: begin
          if (load) begin
            m_axis_tvalid <= accept;
            if (accept) begin
              m_axis_tdata <= y_val;
              m_axis_tlast <= 1'b0;
            end
          end
          if (accept) begin
            if (pix_cnt == LAST_IDX) begin
              pix_cnt <= '0;
              rd_cnt  <= '0;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        CB: begin
          if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= cb_buf[rd_cnt];
            m_axis_tlast  <= 1'b0;
            rd_cnt        <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + 1'b1;
          end
        end
        CR: begin
          if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= cr_buf[rd_cnt];
            m_axis_tlast  <= (rd_cnt == LAST_IDX);
            if (rd_cnt == LAST_IDX) begin
              rd_cnt  <= '0;
              pix_cnt <= '0;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Chroma storage needs no reset: every entry is rewritten before it is drained.
  always_ff @(posedge aclk) begin
    if (accept) begin
      cb_buf[pix_cnt] <= cb_val;
      cr_buf[pix_cnt] <= cr_val;
    end
  end

`ifdef CSC_TLAST_CHECK_EN
  always_ff @(posedge aclk) begin
    if (!aresetn)
      frame_err <= 1'b0;
    else if (accept && (s_axis_tlast != (pix_cnt == LAST_IDX)))
      frame_err <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign frame_err    = 1'b0;
`endif

endmodule

// File: doc/rgb_to_ycbcr_planar.md
# rgb_to_ycbcr_planar

Colour-space front end of the JPEG encoder IP. Accepts one 16x16 MCU of packed RGB pixels on an AXI-Stream slave and emits the MCU as a planar 8-bit stream: 256 Y, then 256 Cb, then 256 Cr, 768 bytes per frame. This is exactly the format the chroma downsampling stage directly downstream consumes. Y is forwarded on the fly; Cb and Cr are buffered and drained after the luma plane.

## Interface
- PIXELS, 256: pixels per frame; power of two, at least 2. Output frame length is 3*PIXELS.
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low; clock aclk
- s_axis_tdata  in  24  pixel {R[23:16], G[15:8], B[7:0]}, raster order
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end of input frame; used only for checking, see Configuration
- m_axis_tdata  out  8  Y/Cb/Cr sample
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  high on output byte 3*PIXELS-1, the last Cr
- frame_err  out  1  sticky tlast-mismatch flag

## Operation
- States:
  - LUMA: accept pixels and emit Y.
  - CB: drain the Cb buffer.
  - CR: drain the Cr buffer.
  - Reset state is LUMA.
- Output register: one stage holds m_axis_tdata, m_axis_tvalid and m_axis_tlast.
  - It loads when `load = !m_axis_tvalid || m_axis_tready`.
  - m_axis_tvalid clears if `load` is true and there is nothing to load.
- LUMA:
  - s_axis_tready = load, forced 0 while aresetn is low.
  - On each accepted pixel, at index pix_cnt:
    - load Y into the output register;
    - write Cb to cb_buf[pix_cnt] and Cr to cr_buf[pix_cnt];
    - increment pix_cnt.
  - Acceptance of pixel PIXELS-1: go to CB, rd_cnt=0.
- CB:
  - s_axis_tready=0.
  - On `load`, output cb_buf[rd_cnt] and increment rd_cnt.
  - After index PIXELS-1 is loaded: go to CR, rd_cnt=0.
- CR:
  - Same as CB, reading cr_buf.
  - Index PIXELS-1 is loaded with tlast=1.
  - Go to LUMA, pix_cnt=0.
- Arithmetic:
  - All products and sums are signed 18-bit.
  - Shifts are arithmetic.
  - Each result is clamped to 0..255.
- Conversion equations:
  - Y = (77R + 150G + 29B + 128) >>> 8
  - Cb = ((-43R - 85G + 128B + 128) >>> 8) + 128
  - Cr = ((128R - 107G - 21B + 128) >>> 8) + 128
- Buffers: two PIXELS x 8 register arrays, read combinationally.
  - Write and read never coincide within a frame, so there is no hazard.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, frame_err=0.
  - pix_cnt=0, rd_cnt=0, state LUMA.
- Reset mid-frame discards all partial data. The first pixel after reset is pixel 0 of a new frame.
- Latency: Y appears on the output the cycle after its pixel handshake.
- Throughput:
  - 1 pixel/cycle in LUMA, 1 byte/cycle in CB and CR when m_axis_tready=1.
  - Minimum 3*PIXELS cycles per frame.
- Backpressure:
  - m_axis_tready=0 holds m_axis_tdata and m_axis_tlast stable and stops s_axis_tready.
  - m_axis_tready=0 also stops the buffer drain.
- Boundaries:
  - The cycle the last Cr is loaded, state becomes LUMA.
  - s_axis_tready may assert the next cycle, when the output register empties.
  - There are no idle bubbles between frames under full throughput.
- Y/Cb/Cr transitions: m_axis_tvalid stays asserted (no bubble) when m_axis_tready=1.

## Configuration
- CSC_TLAST_CHECK_EN defined:
  - An accepted pixel with s_axis_tlast mismatching (pix_cnt==PIXELS-1) sets frame_err.
  - frame_err is sticky until reset.
  - Framing remains count-based regardless.
- Not defined:
  - frame_err is tied to 0.
  - s_axis_tlast is ignored.

## Test plan
- Frame of 256 x 0xFFFFFF -> 256 x 0xFF, then 256 x 0x80, then 256 x 0x80; tlast only on byte 767.
- Frame of 0x0000FF (blue) -> Y=29, Cb=255 (clamped from 256), Cr=107.
- Frame of 0xFF0000 (red) -> Y=77, Cb=85, Cr=255; black 0x000000 -> Y=0, Cb=128, Cr=128.
- Ramp pixel[i]={i,i,i} with random m_axis_tready and s_axis_tvalid gaps:
  - Y[i]=i and Cb=Cr=128.
  - Data is stable while stalled.
  - Order Y/Cb/Cr is preserved.
- Two back-to-back frames with constant ready -> 1536 contiguous valid bytes and two tlast pulses.
- Reset asserted after 100 pixels, then a full frame:
  - Only the new frame's 768 bytes appear.
  - With CSC_TLAST_CHECK_EN, tlast on pixel 10 sets frame_err=1.
